// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a ROWS x COLS key matrix, debounces whole frames and hands out one key code per press
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    localparam int CW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ack,
    output logic            key_held,
    output logic            multi,
    output logic            overrun
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(COLS);
    localparam int BW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_MULTI} state_t;

    state_t          state;
    logic [ROWS-1:0] row_s1, row_s2;
    logic [DW-1:0]   dwell;
    logic [IW-1:0]   cidx, cidx_nxt;
    logic            sample, close;
    logic [1:0]      s_cnt, f_cnt, n_cnt;
    logic [2:0]      sum;
    logic [RW-1:0]   s_row;
    logic [CW-1:0]   s_idx, f_idx, n_idx;
    logic [1:0]      cls, p_cls, a_cls, acc_cls;
    logic [CW-1:0]   idx, p_idx, a_idx, acc_idx;
    logic [BW-1:0]   db_cnt, db_nxt;
    logic            same, accept, acc_stb, press;

    // two-flop synchroniser; idle rows read as released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // pressed-key tally for the current column and its lowest row; frame classes are 0 none, 1 single, 2 multi
    always_comb begin
        s_cnt = '0;
        s_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) begin
                s_cnt = (s_cnt == 2'd2) ? 2'd2 : s_cnt + 2'd1;
                s_row = RW'(r);
            end
        end
    end

    assign sample   = dwell == DW'(SCAN_DIV - 1);
    assign close    = sample && cidx == IW'(COLS - 1);
    assign cidx_nxt = (cidx == IW'(COLS - 1)) ? '0 : cidx + 1'b1;
    assign s_idx    = CW'(int'(cidx) * ROWS + int'(s_row));
    assign sum      = {1'b0, f_cnt} + {1'b0, s_cnt};
    assign n_cnt    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    assign n_idx    = (f_cnt != 2'd0) ? f_idx : s_idx;
    assign cls      = n_cnt;
    assign idx      = (n_cnt == 2'd1) ? n_idx : '0;
    assign same     = cls == p_cls && idx == p_idx;
    assign db_nxt   = same ? ((db_cnt == BW'(DEBOUNCE)) ? db_cnt : db_cnt + 1'b1) : BW'(1);
    assign accept   = db_nxt == BW'(DEBOUNCE) && (cls != a_cls || idx != a_idx);
    assign press    = acc_stb && acc_cls == 2'd1 && (state != S_DOWN || acc_idx != key_code);

    // column dwell timer and one-cold strobe generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell <= '0;
            cidx  <= '0;
            col   <= ~COLS'(1);
        end else if (sample) begin
            dwell <= '0;
            cidx  <= cidx_nxt;
            col   <= ~(COLS'(1) << cidx_nxt);
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // frame accumulator, emptied when the last column's sample closes the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_cnt <= '0;
            f_idx <= '0;
        end else if (sample) begin
            f_cnt <= close ? '0 : n_cnt;
            f_idx <= close ? '0 : n_idx;
        end
    end

    // frame debounce: count identical closed frames and accept a change once stable long enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt  <= '0;
            p_cls   <= '0;
            p_idx   <= '0;
            a_cls   <= '0;
            a_idx   <= '0;
            acc_stb <= 1'b0;
            acc_cls <= '0;
            acc_idx <= '0;
        end else begin
            acc_stb <= close && accept;
            if (close) begin
                db_cnt  <= db_nxt;
                p_cls   <= cls;
                p_idx   <= idx;
                acc_cls <= cls;
                acc_idx <= idx;
            end
            if (close && accept) begin
                a_cls <= cls;
                a_idx <= idx;
            end
        end
    end

    // key state machine and valid/ack handshake; a new press beats a simultaneous ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi     <= 1'b0;
            overrun   <= 1'b0;
        end else if (press) begin
            state     <= S_DOWN;
            key_code  <= acc_idx;
            key_held  <= 1'b1;
            multi     <= 1'b0;
            key_valid <= 1'b1;
            overrun   <= key_valid && !key_ack;
        end else begin
            if (acc_stb) begin
                state    <= (acc_cls == 2'd2) ? S_MULTI : S_IDLE;
                key_held <= 1'b0;
                multi    <= acc_cls == 2'd2;
            end
            if (key_valid && key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: emulates a key matrix, predicts outputs from frame-level rules and checks every cycle
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2;
    localparam int NK = ROWS * COLS, CW = 4;
    localparam int NONE = -1, MANY = -2;

    logic clk = 1'b0, rst = 1'b0, key_ack = 1'b0;
    logic [ROWS-1:0] row = '1;
    logic [COLS-1:0] col;
    logic [CW-1:0] key_code;
    logic key_valid, key_held, multi, overrun;
    logic [NK-1:0] pressed = '0;
    int checks = 0, errors = 0;

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code), .key_valid(key_valid),
        .key_ack(key_ack), .key_held(key_held), .multi(multi), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: edge count k, row history, and a list of keys seen in each frame
    int k = 0, mcol = 0, run = 0, last = NONE, accepted = NONE, pend_fr = NONE, c_s = 0, fr = NONE;
    bit pend = 0;
    logic [ROWS-1:0] rh1 = '1, rh2 = '1;
    int keys[$];
    int m_code = 0;
    bit m_valid = 0, m_held = 0, m_multi = 0, m_ovr = 0;
    logic [COLS+CW+3:0] exp_v;
    int sel, n;

    // advance the model one clock; samples use the row level seen two edges earlier
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k = 0; mcol = 0; run = 0; last = NONE; accepted = NONE; pend = 0;
            rh1 = '1; rh2 = '1; keys.delete();
            m_code = 0; m_valid = 0; m_held = 0; m_multi = 0; m_ovr = 0;
        end else begin
            k++;
            if (pend && pend_fr >= 0) begin
                m_ovr = m_valid && !key_ack;
                m_valid = 1; m_code = pend_fr; m_held = 1; m_multi = 0;
            end else begin
                if (pend) begin m_held = 0; m_multi = (pend_fr == MANY); end
                if (m_valid && key_ack) begin m_valid = 0; m_ovr = 0; end
            end
            pend = 0;
            if (k % SCAN_DIV == 0) begin
                c_s = (k / SCAN_DIV - 1) % COLS;
                for (int r = 0; r < ROWS; r++) if (!rh2[r]) keys.push_back(c_s * ROWS + r);
                if (c_s == COLS - 1) begin
                    fr = (keys.size() == 0) ? NONE : (keys.size() == 1) ? keys[0] : MANY;
                    keys.delete();
                    if (fr == last) run++;
                    else begin run = 1; last = fr; end
                    if (run >= DEBOUNCE && fr != accepted) begin accepted = fr; pend = 1; pend_fr = fr; end
                end
            end
            rh2 = rh1; rh1 = row;
            mcol = (k / SCAN_DIV) % COLS;
        end
    end

    // key matrix: a row reads low when a pressed key sits on the strobed column
    always @(negedge clk) begin
        row = '1;
        for (int r = 0; r < ROWS; r++) if (pressed[mcol * ROWS + r]) row[r] = 1'b0;
    end

    // compare every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            exp_v = {~(COLS'(1) << mcol), CW'(m_code), m_valid, m_held, m_multi, m_ovr};
            chk("cycle {col,code,valid,held,multi,ovr}", {col, key_code, key_valid, key_held, multi, overrun}, exp_v);
        end
    end

    function automatic bit cond(input int what);
        return (what == 0) ? key_valid : (what == 1) ? !key_held : (key_held && key_code == CW'(6));
    endfunction

    task automatic wait_for(input int what, input string nm);
        int w = 0;
        while (!cond(what) && w < 60) begin @(posedge clk); #1; w++; end
        chk({nm, " reached"}, cond(what), 1);
        chk({nm, " within 52"}, w <= 52, 1);
    endtask

    task automatic cycles(input int c);
        repeat (c) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        cycles(1);
        key_ack = 1'b0;
    endtask

    initial begin
        cycles(3);
        chk("reset state", {col, key_code, key_valid, key_held, multi, overrun}, 12'hE00);
        rst = 1'b1;
        cycles(40);

        pressed[9] = 1'b1;
        wait_for(0, "key9 valid");
        chk("key9 code/held", {key_code, key_held}, {4'd9, 1'b1});
        pulse_ack();
        chk("key9 after ack", {key_valid, key_held}, 2'b01);
        pressed = '0;
        wait_for(1, "key9 release");

        sel = 0;
        pressed[9] = 1'b1;
        repeat (16) begin cycles(1); if (key_valid) sel = 1; end
        pressed = '0;
        repeat (60) begin cycles(1); if (key_valid) sel = 1; end
        chk("bounce no event", sel, 0);
        pressed[9] = 1'b1;
        wait_for(0, "hold9 valid");
        chk("hold9 code", key_code, 9);
        pulse_ack();
        pressed = '0;
        wait_for(1, "hold9 release");

        pressed[0] = 1'b1; pressed[15] = 1'b1;
        cycles(60);
        chk("multi state", {multi, key_held, key_valid}, 3'b100);
        pressed[15] = 1'b0;
        wait_for(0, "multi to key0");
        chk("key0 after multi", {key_code, key_held, multi}, {4'd0, 2'b10});
        pulse_ack();
        pressed = '0;
        wait_for(1, "key0 release");

        pressed[5] = 1'b1;
        wait_for(0, "key5 valid");
        pressed = '0;
        wait_for(1, "key5 release");
        pressed[6] = 1'b1;
        wait_for(2, "key6 held");
        chk("overrun set", {key_code, key_valid, overrun}, {4'd6, 2'b11});
        pulse_ack();
        chk("overrun cleared", {key_valid, overrun}, 2'b00);
        pressed = '0;
        wait_for(1, "key6 release");

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            pressed = '0;
            if (sel >= 3) pressed[$urandom_range(0, NK - 1)] = 1'b1;
            if (sel >= 8) pressed[$urandom_range(0, NK - 1)] = 1'b1;
            n = $urandom_range(5, 60);
            repeat (n) begin key_ack = ($urandom_range(0, 3) == 0); cycles(1); end
        end
        pressed = '0;
        key_ack = 1'b1;
        cycles(60);
        key_ack = 1'b0;

        pressed[3] = 1'b1;
        wait_for(0, "key3 valid");
        cycles($urandom_range(1, 10));
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("async reset", {col, key_code, key_valid, key_held, multi, overrun}, 12'hE00);
        pressed = '0;
        cycles(2);
        rst = 1'b1;
        cycles(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
